// File: rtl/wb_arb_pkg.sv
// rtl/wb_arb_pkg.sv - shared types and constants for the two-master wishbone arbiter
package wb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } arb_state_t;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_M0   = 2'b01;
    localparam logic [1:0] GRANT_M1   = 2'b10;

    function automatic logic [1:0] grant_of(input arb_state_t s);
        case (s)
            GNT0:    grant_of = GRANT_M0;
            GNT1:    grant_of = GRANT_M1;
            default: grant_of = GRANT_NONE;
        endcase
    endfunction

endpackage

// File: rtl/wb_arb_watchdog.sv
// rtl/wb_arb_watchdog.sv - per-access timeout counter for the granted strobe
//
// Ports:
//   clk, rst  clock, asynchronous active-high reset
//   stb_i     granted master is strobing (cyc & stb)
//   resp_i    slave answered this cycle (ack | err | rty)
//   clr_i     grant is changing at the next edge
//   expire_o  this is the TIMEOUT-th unanswered strobe cycle
module wb_arb_watchdog
    import wb_arb_pkg::*;
#(
    parameter int TIMEOUT = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic stb_i,
    input  logic resp_i,
    input  logic clr_i,
    output logic expire_o
);

    localparam bit           EN   = (TIMEOUT > 0);
    localparam int           CW   = EN ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LAST = CW'(EN ? TIMEOUT - 1 : 0);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // expire deliberately ignores resp_i: the top uses it to withhold stb
    // from the slave, and the slave's ack may depend on stb combinationally.
    // The top masks the forced error with resp_i instead.
    assign expire_o = EN && stb_i && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (!stb_i || resp_i || clr_i || expire_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/wb_bram_arbiter.sv
// rtl/wb_bram_arbiter.sv - round-robin two-master wishbone arbiter with access watchdog
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   wb_s0_*         master 0 side (wins ties after reset)
//   wb_s1_*         master 1 side
//   wb_m_*          towards the wb_bram slave
//   grant_o         one-hot owner: bit0 master 0, bit1 master 1, 00 idle
module wb_bram_arbiter
    import wb_arb_pkg::*;
#(
    parameter int TIMEOUT = 256,
    parameter int DW      = 32,
    parameter int AW      = 32,
    parameter int SW      = DW / 8
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          wb_s0_cyc_i,
    input  logic          wb_s0_stb_i,
    input  logic          wb_s0_we_i,
    input  logic [AW-1:0] wb_s0_adr_i,
    input  logic [SW-1:0] wb_s0_sel_i,
    input  logic [DW-1:0] wb_s0_dat_i,
    output logic [DW-1:0] wb_s0_dat_o,
    output logic          wb_s0_ack_o,
    output logic          wb_s0_err_o,
    output logic          wb_s0_rty_o,

    input  logic          wb_s1_cyc_i,
    input  logic          wb_s1_stb_i,
    input  logic          wb_s1_we_i,
    input  logic [AW-1:0] wb_s1_adr_i,
    input  logic [SW-1:0] wb_s1_sel_i,
    input  logic [DW-1:0] wb_s1_dat_i,
    output logic [DW-1:0] wb_s1_dat_o,
    output logic          wb_s1_ack_o,
    output logic          wb_s1_err_o,
    output logic          wb_s1_rty_o,

    output logic          wb_m_cyc_o,
    output logic          wb_m_stb_o,
    output logic          wb_m_we_o,
    output logic [AW-1:0] wb_m_adr_o,
    output logic [SW-1:0] wb_m_sel_o,
    output logic [DW-1:0] wb_m_dat_o,
    input  logic [DW-1:0] wb_m_dat_i,
    input  logic          wb_m_ack_i,
    input  logic          wb_m_err_i,
    input  logic          wb_m_rty_i,

    output logic [1:0]    grant_o
);

    arb_state_t state_q, state_d;
    logic       last_q, last_d;
    logic [1:0] grant_q;

    logic       sel0;
    logic       sel1;
    logic       gnt_stb;
    logic       resp;
    logic       wd_expire;
    logic       wd_clr;
    logic       forced_err;

    // Next-state: tie in IDLE goes to the master that was not served last;
    // the owner keeps the bus until it drops cyc, then hands off directly.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (wb_s0_cyc_i && wb_s1_cyc_i) begin
                    state_d = last_q ? GNT0 : GNT1;
                end else if (wb_s0_cyc_i) begin
                    state_d = GNT0;
                end else if (wb_s1_cyc_i) begin
                    state_d = GNT1;
                end
            end
            GNT0: begin
                if (!wb_s0_cyc_i) begin
                    last_d  = 1'b0;
                    state_d = wb_s1_cyc_i ? GNT1 : IDLE;
                end
            end
            GNT1: begin
                if (!wb_s1_cyc_i) begin
                    last_d  = 1'b1;
                    state_d = wb_s0_cyc_i ? GNT0 : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            grant_q <= GRANT_NONE;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            grant_q <= grant_of(state_d);
        end
    end

    assign grant_o = grant_q;
    assign sel0    = (state_q == GNT0);
    assign sel1    = (state_q == GNT1);

    assign gnt_stb = (sel0 && wb_s0_cyc_i && wb_s0_stb_i) ||
                     (sel1 && wb_s1_cyc_i && wb_s1_stb_i);
    assign resp    = wb_m_ack_i || wb_m_err_i || wb_m_rty_i;
    assign wd_clr  = (state_d != state_q);

    wb_arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk      (clk),
        .rst      (rst),
        .stb_i    (gnt_stb),
        .resp_i   (resp),
        .clr_i    (wd_clr),
        .expire_o (wd_expire)
    );

    assign forced_err = wd_expire && !resp;

    // Request mux towards the slave; everything low while idle.
    always_comb begin
        wb_m_cyc_o = 1'b0;
        wb_m_stb_o = 1'b0;
        wb_m_we_o  = 1'b0;
        wb_m_adr_o = '0;
        wb_m_sel_o = '0;
        wb_m_dat_o = '0;
        if (sel0) begin
            wb_m_cyc_o = wb_s0_cyc_i;
            wb_m_stb_o = wb_s0_stb_i && !wd_expire;
            wb_m_we_o  = wb_s0_we_i;
            wb_m_adr_o = wb_s0_adr_i;
            wb_m_sel_o = wb_s0_sel_i;
            wb_m_dat_o = wb_s0_dat_i;
        end else if (sel1) begin
            wb_m_cyc_o = wb_s1_cyc_i;
            wb_m_stb_o = wb_s1_stb_i && !wd_expire;
            wb_m_we_o  = wb_s1_we_i;
            wb_m_adr_o = wb_s1_adr_i;
            wb_m_sel_o = wb_s1_sel_i;
            wb_m_dat_o = wb_s1_dat_i;
        end
    end

    assign wb_s0_dat_o = wb_m_dat_i;
    assign wb_s1_dat_o = wb_m_dat_i;

    assign wb_s0_ack_o = sel0 && wb_m_ack_i;
    assign wb_s0_err_o = sel0 && (wb_m_err_i || forced_err);
    assign wb_s0_rty_o = sel0 && wb_m_rty_i;
    assign wb_s1_ack_o = sel1 && wb_m_ack_i;
    assign wb_s1_err_o = sel1 && (wb_m_err_i || forced_err);
    assign wb_s1_rty_o = sel1 && wb_m_rty_i;

endmodule

// File: tb/tb_wb_bram_arbiter.sv
// tb/tb_wb_bram_arbiter.sv - directed self-checking bench for wb_bram_arbiter
module tb_wb_bram_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic        m0_cyc = 0, m0_stb = 0, m0_we = 0;
    logic [31:0] m0_adr = 0, m0_wdat = 0;
    logic [3:0]  m0_sel = 4'hF;
    logic        m1_cyc = 0, m1_stb = 0, m1_we = 0;
    logic [31:0] m1_adr = 0, m1_wdat = 0;
    logic [3:0]  m1_sel = 4'hF;

    logic [31:0] m0_rdat, m1_rdat;
    logic        m0_ack, m0_err, m0_rty, m1_ack, m1_err, m1_rty;
    logic        s_cyc, s_stb, s_we;
    logic [31:0] s_adr, s_wdat;
    logic [3:0]  s_sel;
    logic [31:0] s_rdat;
    logic        s_ack;
    logic        s_err = 1'b0;
    logic        s_rty = 1'b0;
    logic [1:0]  grant;

    logic [31:0] nt_m0_rdat, nt_m1_rdat;
    logic        nt_m0_ack, nt_m0_err, nt_m0_rty, nt_m1_ack, nt_m1_err, nt_m1_rty;
    logic        nt_cyc, nt_stb, nt_we;
    logic [31:0] nt_adr, nt_wdat;
    logic [3:0]  nt_sel;
    logic [1:0]  nt_grant;
    logic [31:0] zero32 = 32'h0;
    logic        zero1  = 1'b0;

    wb_bram_arbiter #(.TIMEOUT(4)) u_dut (
        .clk(clk), .rst(rst),
        .wb_s0_cyc_i(m0_cyc), .wb_s0_stb_i(m0_stb), .wb_s0_we_i(m0_we),
        .wb_s0_adr_i(m0_adr), .wb_s0_sel_i(m0_sel), .wb_s0_dat_i(m0_wdat),
        .wb_s0_dat_o(m0_rdat), .wb_s0_ack_o(m0_ack), .wb_s0_err_o(m0_err), .wb_s0_rty_o(m0_rty),
        .wb_s1_cyc_i(m1_cyc), .wb_s1_stb_i(m1_stb), .wb_s1_we_i(m1_we),
        .wb_s1_adr_i(m1_adr), .wb_s1_sel_i(m1_sel), .wb_s1_dat_i(m1_wdat),
        .wb_s1_dat_o(m1_rdat), .wb_s1_ack_o(m1_ack), .wb_s1_err_o(m1_err), .wb_s1_rty_o(m1_rty),
        .wb_m_cyc_o(s_cyc), .wb_m_stb_o(s_stb), .wb_m_we_o(s_we),
        .wb_m_adr_o(s_adr), .wb_m_sel_o(s_sel), .wb_m_dat_o(s_wdat),
        .wb_m_dat_i(s_rdat), .wb_m_ack_i(s_ack), .wb_m_err_i(s_err), .wb_m_rty_i(s_rty),
        .grant_o(grant)
    );

    wb_bram_arbiter #(.TIMEOUT(0)) u_nt (
        .clk(clk), .rst(rst),
        .wb_s0_cyc_i(m0_cyc), .wb_s0_stb_i(m0_stb), .wb_s0_we_i(m0_we),
        .wb_s0_adr_i(m0_adr), .wb_s0_sel_i(m0_sel), .wb_s0_dat_i(m0_wdat),
        .wb_s0_dat_o(nt_m0_rdat), .wb_s0_ack_o(nt_m0_ack), .wb_s0_err_o(nt_m0_err), .wb_s0_rty_o(nt_m0_rty),
        .wb_s1_cyc_i(m1_cyc), .wb_s1_stb_i(m1_stb), .wb_s1_we_i(m1_we),
        .wb_s1_adr_i(m1_adr), .wb_s1_sel_i(m1_sel), .wb_s1_dat_i(m1_wdat),
        .wb_s1_dat_o(nt_m1_rdat), .wb_s1_ack_o(nt_m1_ack), .wb_s1_err_o(nt_m1_err), .wb_s1_rty_o(nt_m1_rty),
        .wb_m_cyc_o(nt_cyc), .wb_m_stb_o(nt_stb), .wb_m_we_o(nt_we),
        .wb_m_adr_o(nt_adr), .wb_m_sel_o(nt_sel), .wb_m_dat_o(nt_wdat),
        .wb_m_dat_i(zero32), .wb_m_ack_i(zero1), .wb_m_err_i(zero1), .wb_m_rty_i(zero1),
        .grant_o(nt_grant)
    );

    // BRAM stub: combinational write ack, read ack one cycle after stb.
    // Addresses below 0x20 hit a small memory, higher ones return B00000xx.
    logic        silent = 1'b0;
    logic        rd_ack_q;
    logic [31:0] rd_dat_q;
    logic [31:0] mem [0:31];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ack_q <= 1'b0;
        end else begin
            rd_ack_q <= !silent && s_cyc && s_stb && !s_we && !rd_ack_q;
        end
    end

    always @(posedge clk) begin
        if (s_cyc && s_stb && !s_we) begin
            rd_dat_q <= (s_adr[7:5] == 3'd0) ? mem[s_adr[4:0]] : {24'hB00000, s_adr[7:0]};
        end
        if (s_cyc && s_stb && s_we && !silent) begin
            mem[s_adr[4:0]] <= s_wdat;
        end
    end

    assign s_ack  = !silent && ((s_cyc && s_stb && s_we) || (rd_ack_q && s_cyc && s_stb));
    assign s_rdat = rd_dat_q;

    int nt_err_cnt = 0;
    always @(negedge clk) begin
        if (nt_m0_err || nt_m1_err) nt_err_cnt <= nt_err_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit got;
        int err_cnt;
        logic [1:0] exp_g;

        // reset state
        #3;
        chk("rst_grant", grant, 2'b00);
        chk("rst_cyc", s_cyc, 1'b0);
        chk("rst_m0_ack", m0_ack, 1'b0);
        tick();
        rst = 1'b0;

        // master 0 write then read back
        m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_adr = 32'h010; m0_wdat = 32'hCAFE0001;
        @(negedge clk);
        chk("wr_req_grant", grant, 2'b00);
        chk("wr_req_stb", s_stb, 1'b0);
        tick();
        @(negedge clk);
        chk("wr_grant", grant, 2'b01);
        chk("wr_stb", s_stb, 1'b1);
        chk("wr_adr", s_adr, 32'h010);
        chk("wr_ack", m0_ack, 1'b1);
        chk("wr_m1_ack", m1_ack, 1'b0);
        tick();
        m0_we = 0;
        @(negedge clk);
        chk("rd_wait_ack", m0_ack, 1'b0);
        tick();
        @(negedge clk);
        chk("rd_ack", m0_ack, 1'b1);
        chk("rd_data", m0_rdat, 32'hCAFE0001);
        chk("rd_m1_ack", m1_ack, 1'b0);
        chk("rd_bcast", m1_rdat, 32'hCAFE0001);
        tick();
        m0_cyc = 0; m0_stb = 0;
        tick();
        chk("rd_done_grant", grant, 2'b00);

        // tie after reset, handoff, then alternation
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m0_cyc = 1; m1_cyc = 1;
        tick();
        chk("tie0_grant", grant, 2'b01);
        tick();
        chk("tie0_hold", grant, 2'b01);
        m0_cyc = 0;
        @(negedge clk);
        chk("handoff_gap_grant", grant, 2'b01);
        chk("handoff_gap_cyc", s_cyc, 1'b0);
        tick();
        chk("handoff_grant", grant, 2'b10);
        chk("handoff_cyc", s_cyc, 1'b1);
        m1_cyc = 0;
        tick();
        chk("handoff_idle", grant, 2'b00);
        for (int t = 0; t < 4; t++) begin
            exp_g = (t % 2 == 0) ? 2'b01 : 2'b10;
            m0_cyc = 1; m1_cyc = 1;
            tick();
            chk($sformatf("alt%0d_grant", t), grant, exp_g);
            m0_cyc = 0; m1_cyc = 0;
            tick();
            chk($sformatf("alt%0d_idle", t), grant, 2'b00);
        end

        // 8-word burst by master 0 while master 1 waits
        m0_cyc = 1; m0_stb = 1; m0_we = 0; m0_adr = 32'h20;
        tick();
        chk("burst_grant0", grant, 2'b01);
        m1_cyc = 1; m1_stb = 1; m1_we = 0; m1_adr = 32'h30;
        for (int k = 0; k < 8; k++) begin
            got = 0;
            for (int c = 0; c < 4 && !got; c++) begin
                @(negedge clk);
                chk("burst_grant", grant, 2'b01);
                chk("burst_m1_ack", m1_ack, 1'b0);
                chk("burst_nt_grant", nt_grant, 2'b01);
                if (m0_ack) begin
                    got = 1;
                    chk($sformatf("burst_dat%0d", k), m0_rdat, 32'hB0000020 + k);
                end
                tick();
            end
            chk($sformatf("burst_ack%0d_seen", k), got, 1'b1);
            m0_adr = m0_adr + 1;
        end
        m0_cyc = 0; m0_stb = 0;
        silent = 1;
        tick();
        chk("burst_switch", grant, 2'b10);

        // watchdog: silent slave, master 1 strobing, err on every 4th cycle
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk($sformatf("wd_err_c%0d", c), m1_err, (c % 4 == 3) ? 1'b1 : 1'b0);
            chk($sformatf("wd_stb_c%0d", c), s_stb, (c % 4 == 3) ? 1'b0 : 1'b1);
            chk($sformatf("wd_m0err_c%0d", c), m0_err, 1'b0);
            tick();
        end

        // 1000 silent cycles: 250 forced errors here, none from the disabled watchdog
        err_cnt = 0;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            if (m1_err) err_cnt++;
            tick();
        end
        chk("wd_err_count", err_cnt, 250);
        chk("nt_grant", nt_grant, 2'b10);
        chk("nt_no_err", nt_err_cnt, 0);

        // asynchronous reset in the middle of a master 1 read
        silent = 0;
        tick();
        #2;
        rst = 1'b1;
        #1;
        chk("arst_cyc", s_cyc, 1'b0);
        chk("arst_stb", s_stb, 1'b0);
        chk("arst_grant", grant, 2'b00);
        chk("arst_m1_ack", m1_ack, 1'b0);
        m0_cyc = 1; m0_stb = 1; m0_adr = 32'h21;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("arst_rel_grant", grant, 2'b00);
        tick();
        chk("arst_first_grant", grant, 2'b01);
        chk("arst_first_adr", s_adr, 32'h21);
        m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
